// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - PIO completer request/status codes, FSM states and CC descriptor packing
package pio_pkg;

  localparam logic [3:0] MEM_RD = 4'b0000;
  localparam logic [3:0] MEM_WR = 4'b0001;
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  // CQ sideband and beat1 ({DW3,DW2}) field offsets
  localparam int CQ_SOP_BIT    = 40;
  localparam int CQ_DWCNT_LSB  = 0;
  localparam int CQ_TYPE_LSB   = 11;
  localparam int CQ_REQID_LSB  = 16;
  localparam int CQ_TAG_LSB    = 32;
  localparam int CQ_TC_LSB     = 57;
  localparam int CQ_ATTR_LSB   = 60;

  // CC descriptor field offsets within their dwords
  localparam int CC_BCNT_LSB   = 16;
  localparam int CC_STATUS_LSB = 11;
  localparam int CC_REQID_LSB  = 16;
  localparam int CC_CPLID_LSB  = 8;
  localparam int CC_TC_LSB     = 25;
  localparam int CC_ATTR_LSB   = 28;

  typedef enum logic [2:0] {
    S_IDLE, S_DESC, S_WDATA, S_RD_ISSUE, S_RD_WAIT, S_CC0, S_CC1, S_DRAIN
  } state_e;

  function automatic logic [31:0] cc_dw0(input logic [6:0] lower_addr, input logic [12:0] byte_count);
    logic [31:0] dw;
    dw = '0;
    dw[6:0] = lower_addr;
    dw[CC_BCNT_LSB +: 13] = byte_count;
    return dw;
  endfunction

  function automatic logic [31:0] cc_dw1(input logic [10:0] dword_count, input logic [2:0] status,
                                         input logic [15:0] requester_id);
    logic [31:0] dw;
    dw = '0;
    dw[10:0] = dword_count;
    dw[CC_STATUS_LSB +: 3] = status;
    dw[CC_REQID_LSB +: 16] = requester_id;
    return dw;
  endfunction

  function automatic logic [31:0] cc_dw2(input logic [7:0] tag, input logic [15:0] completer_id,
                                         input logic [2:0] tc, input logic [2:0] attr);
    logic [31:0] dw;
    dw = '0;
    dw[7:0] = tag;
    dw[CC_CPLID_LSB +: 16] = completer_id;
    dw[CC_TC_LSB +: 3] = tc;
    dw[CC_ATTR_LSB +: 3] = attr;
    return dw;
  endfunction

endpackage

// File: rtl/pio_cq_completer.sv
// rtl/pio_cq_completer.sv - CQ request consumer driving a register bus and returning CC read completions
module pio_cq_completer #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [C_DATA_WIDTH-1:0] cq_tdata,
  input  logic [84:0]             cq_tuser,
  input  logic                    cq_tlast,
  input  logic [KEEP_WIDTH-1:0]   cq_tkeep,
  input  logic                    cq_tvalid,
  output logic                    cq_tready,
  output logic [C_DATA_WIDTH-1:0] cc_tdata,
  output logic [32:0]             cc_tuser,
  output logic                    cc_tlast,
  output logic [KEEP_WIDTH-1:0]   cc_tkeep,
  output logic                    cc_tvalid,
  input  logic                    cc_tready,
  input  logic [15:0]             completer_id,
  output logic                    reg_wr_en,
  output logic [ADDR_WIDTH-3:0]   reg_wr_addr,
  output logic [31:0]             reg_wr_data,
  output logic [3:0]              reg_wr_be,
  output logic                    reg_rd_en,
  output logic [ADDR_WIDTH-3:0]   reg_rd_addr,
  input  logic [31:0]             reg_rd_data,
  output logic [15:0]             stat_ur_count
);
  import pio_pkg::*;

  state_e                state;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [3:0]            be_q;
  logic [15:0]           req_id_q;
  logic [7:0]            tag_q;
  logic [2:0]            tc_q, attr_q;
  logic                  ur_q;
  logic [31:0]           rd_data_q, wr_data_q;
  logic [31:0]           dw0, dw1, dw2;
  logic                  cq_hs, sop;
  logic [10:0]           dw_count;
  logic [3:0]            req_type;
  logic                  unused_ok;

  assign cq_hs    = cq_tvalid & cq_tready;
  assign sop      = cq_tuser[CQ_SOP_BIT];
  assign dw_count = cq_tdata[CQ_DWCNT_LSB +: 11];
  assign req_type = cq_tdata[CQ_TYPE_LSB +: 4];
  assign unused_ok = ^{cq_tkeep, cq_tuser, cq_tdata};

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      addr_q <= '0; be_q <= '0; req_id_q <= '0; tag_q <= '0; tc_q <= '0; attr_q <= '0;
      ur_q <= 1'b0; rd_data_q <= '0; wr_data_q <= '0;
      reg_wr_en <= 1'b0; reg_rd_en <= 1'b0; stat_ur_count <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      case (state)
        S_IDLE: if (cq_hs) begin
          if (sop && !cq_tlast) begin
            addr_q <= cq_tdata[ADDR_WIDTH-1:2];
            be_q   <= cq_tuser[3:0];
            state  <= S_DESC;
          end else if (!cq_tlast) begin
            state <= S_DRAIN;
          end
        end
        S_DESC: if (cq_hs) begin
          req_id_q <= cq_tdata[CQ_REQID_LSB +: 16];
          tag_q    <= cq_tdata[CQ_TAG_LSB +: 8];
          tc_q     <= cq_tdata[CQ_TC_LSB +: 3];
          attr_q   <= cq_tdata[CQ_ATTR_LSB +: 3];
          ur_q     <= 1'b0;
          if (req_type == MEM_WR && dw_count == 11'd1 && !cq_tlast) begin
            state <= S_WDATA;
          end else if (req_type == MEM_RD && dw_count == 11'd1) begin
            reg_rd_en <= 1'b1;
            state     <= S_RD_ISSUE;
          end else begin
            if (stat_ur_count != 16'hFFFF) stat_ur_count <= stat_ur_count + 16'd1;
            // Only reads get a UR completion; everything else is silently discarded
            if (req_type == MEM_RD) begin
              ur_q      <= 1'b1;
              rd_data_q <= '0;
              state     <= S_CC0;
            end else begin
              state <= cq_tlast ? S_IDLE : S_DRAIN;
            end
          end
        end
        S_WDATA: if (cq_hs) begin
          reg_wr_en <= 1'b1;
          wr_data_q <= cq_tdata[31:0];
          state     <= cq_tlast ? S_IDLE : S_DRAIN;
        end
        S_RD_ISSUE: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          rd_data_q <= reg_rd_data;
          state     <= S_CC0;
        end
        S_CC0:   if (cc_tready) state <= S_CC1;
        S_CC1:   if (cc_tready) state <= S_IDLE;
        S_DRAIN: if (cq_hs && cq_tlast) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dw0 = cc_dw0({addr_q[4:0], 2'b00}, ur_q ? 13'd0 : 13'd4);
  assign dw1 = cc_dw1(ur_q ? 11'd0 : 11'd1, ur_q ? CPL_UR : CPL_SC, req_id_q);
  assign dw2 = cc_dw2(tag_q, completer_id, tc_q, attr_q);

  assign cq_tready = (state == S_IDLE) || (state == S_DESC) || (state == S_WDATA) || (state == S_DRAIN);
  assign cc_tvalid = (state == S_CC0) || (state == S_CC1);
  assign cc_tlast  = (state == S_CC1);
  assign cc_tuser  = '0;
  assign cc_tkeep  = (state == S_CC0) ? KEEP_WIDTH'(2'b11) :
                     (state == S_CC1) ? (ur_q ? KEEP_WIDTH'(2'b01) : KEEP_WIDTH'(2'b11)) : '0;
  assign cc_tdata  = (state == S_CC0) ? {dw1, dw0} :
                     (state == S_CC1) ? {rd_data_q, dw2} : '0;

  assign reg_wr_addr = addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_wr_be   = be_q;
  assign reg_rd_addr = addr_q;

endmodule

// File: tb/tb_pio_cq_completer.sv
// tb/tb_pio_cq_completer.sv - scoreboard bench for pio_cq_completer
module tb_pio_cq_completer;

  logic        user_clk = 1'b0;
  logic        reset;
  logic [63:0] cq_tdata;
  logic [84:0] cq_tuser;
  logic        cq_tlast;
  logic [1:0]  cq_tkeep;
  logic        cq_tvalid;
  logic        cq_tready;
  logic [63:0] cc_tdata;
  logic [32:0] cc_tuser;
  logic        cc_tlast;
  logic [1:0]  cc_tkeep;
  logic        cc_tvalid;
  logic        cc_tready;
  logic [15:0] completer_id;
  logic        reg_wr_en;
  logic [9:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_be;
  logic        reg_rd_en;
  logic [9:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [15:0] stat_ur_count;

  pio_cq_completer dut (
    .user_clk(user_clk), .reset(reset),
    .cq_tdata(cq_tdata), .cq_tuser(cq_tuser), .cq_tlast(cq_tlast), .cq_tkeep(cq_tkeep),
    .cq_tvalid(cq_tvalid), .cq_tready(cq_tready),
    .cc_tdata(cc_tdata), .cc_tuser(cc_tuser), .cc_tlast(cc_tlast), .cc_tkeep(cc_tkeep),
    .cc_tvalid(cc_tvalid), .cc_tready(cc_tready), .completer_id(completer_id),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_be(reg_wr_be),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .stat_ur_count(stat_ur_count)
  );

  always #5 user_clk = ~user_clk;

  typedef struct { logic [9:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  typedef struct { logic [63:0] b0; logic [63:0] b1; logic [1:0] k1; int lat; } cc_t;

  wr_t        exp_wr[$];
  logic [9:0] exp_rd[$];
  cc_t        exp_cc[$];

  int tests = 0, fails = 0;
  int cyc = 0, desc_hs_cyc = 0, ur_model = 0;
  bit tb_owns_rdy = 1'b0;
  logic [31:0] mem [0:1023];
  logic        rd_en_d = 1'b0;
  logic [9:0]  rd_addr_d = '0;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Register file peer: data is valid only in the cycle after the strobe
  always @(posedge user_clk) begin
    rd_en_d   <= reg_rd_en;
    rd_addr_d <= reg_rd_addr;
  end
  assign reg_rd_data = rd_en_d ? mem[rd_addr_d] : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cc_b0(input logic [11:0] a, input int bc, input int dc, input int st,
                                        input logic [15:0] rid);
    logic [31:0] d0, d1;
    d0 = 32'(bc) * 32'h1_0000 + (32'(a) % 32'd128) / 32'd4 * 32'd4;
    d1 = 32'(rid) * 32'h1_0000 + 32'(st) * 32'd2048 + 32'(dc);
    return {d1, d0};
  endfunction

  function automatic logic [63:0] cc_b1(input logic [31:0] rd, input logic [7:0] tag,
                                        input logic [2:0] tc, input logic [2:0] attr);
    logic [31:0] d2;
    d2 = 32'(attr) * 32'h1000_0000 + 32'(tc) * 32'h0200_0000 + 32'(completer_id) * 32'd256 + 32'(tag);
    return {rd, d2};
  endfunction

  // Reference behaviour of one request, expressed as the outputs it must cause
  task automatic model_req(input logic [3:0] typ, input logic [10:0] cnt, input logic [11:0] a,
                           input logic [3:0] be, input int npay, input logic [31:0] data0,
                           input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                           input logic [2:0] attr);
    if (typ == 4'd1 && cnt == 11'd1 && npay > 0) begin
      exp_wr.push_back('{a[11:2], data0, be});
    end else if (typ == 4'd0 && cnt == 11'd1) begin
      exp_rd.push_back(a[11:2]);
      exp_cc.push_back('{cc_b0(a, 4, 1, 0, rid), cc_b1(mem[a[11:2]], tag, tc, attr), 2'b11, 3});
    end else if (typ == 4'd0) begin
      exp_cc.push_back('{cc_b0(a, 0, 0, 1, rid), cc_b1(32'h0, tag, tc, attr), 2'b01, 1});
      ur_model++;
    end else begin
      ur_model++;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic sop, input logic [3:0] be,
                           input logic last, input bit is_desc);
    int n;
    cq_tdata = d; cq_tuser = '0; cq_tuser[40] = sop; cq_tuser[3:0] = be;
    cq_tlast = last; cq_tkeep = 2'b11; cq_tvalid = 1'b1;
    n = 0;
    @(negedge user_clk);
    while (!cq_tready && n < 200) begin @(negedge user_clk); n++; end
    if (!cq_tready) check("cq_accept_timeout", 64'(cq_tready), 64'(1));
    if (is_desc) desc_hs_cyc = cyc;
    @(posedge user_clk); #1;
    cq_tvalid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin @(posedge user_clk); #1; end
  endtask

  task automatic send_req(input logic [3:0] typ, input logic [10:0] cnt, input logic [11:0] a,
                          input logic [3:0] be, input int npay, input logic [31:0] data0,
                          input logic [15:0] rid, input logic [7:0] tag, input logic [2:0] tc,
                          input logic [2:0] attr);
    logic [63:0] b0, b1;
    b0 = {32'($urandom()), 20'($urandom()), a};
    b1 = {1'($urandom()), attr, tc, 17'($urandom()), tag, rid, 1'($urandom()), typ, cnt};
    send_beat(b0, 1'b1, be, 1'b0, 1'b0);
    send_beat(b1, 1'b0, be, npay == 0, 1'b1);
    for (int i = 0; i < npay; i++)
      send_beat({32'($urandom()), (i == 0) ? data0 : 32'($urandom())}, 1'b0, be, i == npay - 1, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_cc.size()) != 0 && n < 300) begin
      @(negedge user_clk); n++;
    end
    check("outstanding_after_req", 64'(exp_wr.size() + exp_rd.size() + exp_cc.size()), 64'(0));
    exp_wr.delete(); exp_rd.delete(); exp_cc.delete();
    repeat (2) @(posedge user_clk);
    #1;
  endtask

  task automatic wait_cc_valid();
    int n;
    n = 0;
    @(negedge user_clk);
    while (!cc_tvalid && n < 100) begin @(negedge user_clk); n++; end
    check("cc_valid_seen", 64'(cc_tvalid), 64'(1));
  endtask

  initial begin
    forever begin
      @(posedge user_clk); #1;
      if (!tb_owns_rdy) cc_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  bit          cc_seen = 0, cc_beat = 0, stalled = 0;
  logic [63:0] held_data;
  logic [2:0]  held_ctl;
  always @(negedge user_clk) begin
    wr_t w;
    cc_t c;
    logic [9:0] ra;
    if (reset) begin
      cc_seen = 0; cc_beat = 0; stalled = 0;
    end else begin
      if (reg_wr_en) begin
        if (exp_wr.size() == 0) check("unexpected_reg_wr", 64'(reg_wr_addr), 64'h3FF_FFFF);
        else begin
          w = exp_wr.pop_front();
          check("reg_wr_addr", 64'(reg_wr_addr), 64'(w.addr));
          check("reg_wr_data", 64'(reg_wr_data), 64'(w.data));
          check("reg_wr_be", 64'(reg_wr_be), 64'(w.be));
        end
      end
      if (reg_rd_en) begin
        if (exp_rd.size() == 0) check("unexpected_reg_rd", 64'(reg_rd_addr), 64'h3FF_FFFF);
        else begin
          ra = exp_rd.pop_front();
          check("reg_rd_addr", 64'(reg_rd_addr), 64'(ra));
        end
      end
      if (cc_tvalid) begin
        check("cq_tready_during_cc", 64'(cq_tready), 64'(0));
        if (stalled) begin
          check("cc_hold_data", cc_tdata, held_data);
          check("cc_hold_ctl", 64'({cc_tlast, cc_tkeep}), 64'(held_ctl));
        end
        if (exp_cc.size() == 0) begin
          if (!cc_seen) check("unexpected_cc", cc_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
          cc_seen = 1;
        end else begin
          c = exp_cc[0];
          if (!cc_seen) begin
            check("cc_latency", 64'(cyc - desc_hs_cyc), 64'(c.lat));
            cc_seen = 1;
          end
          if (cc_tready) begin
            check("cc_tuser", 64'(cc_tuser), 64'(0));
            if (!cc_beat) begin
              check("cc_beat0", cc_tdata, c.b0);
              check("cc_ctl0", 64'({cc_tlast, cc_tkeep}), 64'({1'b0, 2'b11}));
              cc_beat = 1;
            end else begin
              check("cc_beat1", cc_tdata, c.b1);
              check("cc_ctl1", 64'({cc_tlast, cc_tkeep}), 64'({1'b1, c.k1}));
              void'(exp_cc.pop_front());
              cc_beat = 0; cc_seen = 0;
            end
          end
        end
        stalled   = !cc_tready;
        held_data = cc_tdata;
        held_ctl  = {cc_tlast, cc_tkeep};
      end else begin
        if (stalled) check("cc_valid_dropped", 64'(cc_tvalid), 64'(1));
        stalled = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cq_tready"}, 64'(cq_tready), 64'(1));
    check({tag, "_cc_valid_last_keep"}, 64'({cc_tvalid, cc_tlast, cc_tkeep}), 64'(0));
    check({tag, "_cc_tdata"}, cc_tdata, 64'(0));
    check({tag, "_reg_strobes"}, 64'({reg_wr_en, reg_rd_en}), 64'(0));
    check({tag, "_reg_bus"}, 64'({reg_wr_addr, reg_wr_data, reg_wr_be, reg_rd_addr}), 64'(0));
    check({tag, "_ur_count"}, 64'(stat_ur_count), 64'(0));
  endtask

  initial begin
    int k, np;
    logic [11:0] a;
    logic [3:0]  typ;
    logic [10:0] cnt;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    mem[4] = 32'h1234_5678;
    completer_id = 16'h0200;
    reset = 1'b1;
    cq_tdata = '0; cq_tuser = '0; cq_tlast = 1'b0; cq_tkeep = '0; cq_tvalid = 1'b0; cc_tready = 1'b0;
    repeat (3) @(negedge user_clk);
    check_reset_outputs("reset");
    @(posedge user_clk); #1;
    reset = 1'b0;

    // Single write
    exp_wr.push_back('{10'h004, 32'hDEAD_BEEF, 4'hF});
    send_req(4'd1, 11'd1, 12'h010, 4'hF, 1, 32'hDEAD_BEEF, 16'h0, 8'h0, 3'd0, 3'd0);
    wait_idle();

    // Single read with known completion image
    exp_rd.push_back(10'h004);
    exp_cc.push_back('{64'h0100_0001_0004_0010, 64'h1234_5678_0002_0005, 2'b11, 3});
    send_req(4'd0, 11'd1, 12'h010, 4'hF, 0, 32'h0, 16'h0100, 8'h05, 3'd0, 3'd0);
    wait_idle();

    // Same read with the CC consumer stalled for 5 cycles
    tb_owns_rdy = 1'b1; cc_tready = 1'b0;
    exp_rd.push_back(10'h004);
    exp_cc.push_back('{64'h0100_0001_0004_0010, 64'h1234_5678_0002_0005, 2'b11, 3});
    send_req(4'd0, 11'd1, 12'h010, 4'hF, 0, 32'h0, 16'h0100, 8'h05, 3'd0, 3'd0);
    wait_cc_valid();
    repeat (5) @(posedge user_clk);
    #1;
    check("stall_valid_held", 64'(cc_tvalid), 64'(1));
    cc_tready = 1'b1;
    tb_owns_rdy = 1'b0;
    wait_idle();

    // Read with dword_count 2 gets a UR completion
    exp_cc.push_back('{64'h0100_0800_0000_0010, 64'h0000_0000_0002_0005, 2'b01, 1});
    ur_model++;
    send_req(4'd0, 11'd2, 12'h010, 4'hF, 0, 32'h0, 16'h0100, 8'h05, 3'd0, 3'd0);
    wait_idle();
    check("ur_count_after_ur_read", 64'(stat_ur_count), 64'(1));

    // Multi-dword write is drained, then the next write goes through
    ur_model++;
    send_req(4'd1, 11'd4, 12'h020, 4'hF, 3, 32'h1111_2222, 16'h0, 8'h0, 3'd0, 3'd0);
    wait_idle();
    check("ur_count_after_bad_wr", 64'(stat_ur_count), 64'(2));
    exp_wr.push_back('{10'h009, 32'hCAFE_F00D, 4'h3});
    send_req(4'd1, 11'd1, 12'h024, 4'h3, 1, 32'hCAFE_F00D, 16'h0, 8'h0, 3'd0, 3'd0);
    wait_idle();

    // Randomised mix against the reference model
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 7);
      a = 12'($urandom_range(0, 1023) * 4);
      typ = 4'd1; cnt = 11'd1; np = 1;
      case (k)
        0, 1: begin typ = 4'd1; cnt = 11'd1; np = 1; end
        2:    begin typ = 4'd0; cnt = 11'd1; np = 0; end
        3:    begin typ = 4'd0; cnt = 11'($urandom_range(2, 2047)); np = 0; end
        4:    begin typ = 4'd1; cnt = 11'($urandom_range(2, 4)); np = int'(cnt); end
        5:    begin typ = 4'd1; cnt = 11'd1; np = 0; end
        6:    begin typ = 4'($urandom_range(2, 15)); cnt = 11'($urandom_range(1, 4)); np = $urandom_range(0, 2); end
        default: ;
      endcase
      if (k == 7) begin
        np = $urandom_range(1, 3);
        for (int b = 0; b < np; b++)
          send_beat({32'($urandom()), 32'($urandom())}, 1'b0, 4'hF, b == np - 1, 1'b0);
      end else begin
        logic [31:0] d0;
        logic [15:0] rid;
        logic [7:0]  tg;
        logic [2:0]  tc, at;
        logic [3:0]  be;
        d0 = $urandom(); rid = 16'($urandom()); tg = 8'($urandom());
        tc = 3'($urandom()); at = 3'($urandom()); be = 4'($urandom());
        model_req(typ, cnt, a, be, np, d0, rid, tg, tc, at);
        send_req(typ, cnt, a, be, np, d0, rid, tg, tc, at);
      end
      wait_idle();
    end
    check("ur_count_random", 64'(stat_ur_count), 64'(ur_model));

    // Reset while the second CC beat is stalled
    tb_owns_rdy = 1'b1; cc_tready = 1'b0;
    model_req(4'd0, 11'd1, 12'h0A8, 4'hF, 0, 32'h0, 16'h1234, 8'h77, 3'd2, 3'd1);
    send_req(4'd0, 11'd1, 12'h0A8, 4'hF, 0, 32'h0, 16'h1234, 8'h77, 3'd2, 3'd1);
    wait_cc_valid();
    @(posedge user_clk); #1;
    cc_tready = 1'b1;
    @(posedge user_clk); #1;
    cc_tready = 1'b0;
    check("in_cc1_stall", 64'({cc_tvalid, cc_tlast}), 64'(3));
    @(negedge user_clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_cc_valid", 64'(cc_tvalid), 64'(0));
    check("reset_mid_cq_tready", 64'(cq_tready), 64'(1));
    exp_wr.delete(); exp_rd.delete(); exp_cc.delete();
    ur_model = 0;
    @(negedge user_clk);
    check_reset_outputs("reset_mid");
    @(posedge user_clk); #1;
    reset = 1'b0;
    tb_owns_rdy = 1'b0;
    repeat (3) @(negedge user_clk);
    check("no_cc_after_reset", 64'(cc_tvalid), 64'(0));
    @(posedge user_clk); #1;

    model_req(4'd0, 11'd1, 12'h3FC, 4'hF, 0, 32'h0, 16'hBEEF, 8'hA5, 3'd7, 3'd7);
    send_req(4'd0, 11'd1, 12'h3FC, 4'hF, 0, 32'h0, 16'hBEEF, 8'hA5, 3'd7, 3'd7);
    wait_idle();
    check("ur_count_final", 64'(stat_ur_count), 64'(ur_model));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
